// File: rtl/rv32i_types.sv
// Shared rename definitions: architectural register count and physical register index type.
package rv32i_types;
  localparam int ARCH_REGS = 32;
  localparam int PREG_BITS = 6;

  typedef logic [PREG_BITS-1:0] preg_t;
endpackage

// File: rtl/free_list.sv
// Circular FIFO of free physical register indices feeding rename; head is the next pd_dispatch.
// Reads are combinational from registered state, updates land on the next clk, flush refills in one cycle.
module free_list
  import rv32i_types::*;
#(
  parameter int PHYS_REG_BITS = PREG_BITS,
  parameter int NUM_PHYS      = 1 << PHYS_REG_BITS,
  parameter int DEPTH         = NUM_PHYS - ARCH_REGS
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       deq,
  output logic [PHYS_REG_BITS-1:0]   pd_out,
  output logic                       empty,
  input  logic                       enq,
  input  logic [PHYS_REG_BITS-1:0]   pd_in,
  output logic                       full,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  logic [PHYS_REG_BITS-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]         head_q, head_d;
  logic [PTR_W-1:0]         tail_q, tail_d;
  logic [IDX_W-1:0]         head_idx, tail_idx;
  logic                     do_enq, do_deq;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p[IDX_W-1:0] == IDX_W'(DEPTH - 1)) begin
      ptr_inc = {~p[IDX_W], {IDX_W{1'b0}}};
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign head_idx = head_q[IDX_W-1:0];
  assign tail_idx = tail_q[IDX_W-1:0];

  assign empty  = (head_q == tail_q);
  assign full   = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign pd_out = mem_q[head_idx];

  // Physical register 0 is hard-wired x0 and must never re-enter the list.
  assign do_enq = enq && !full && (pd_in != '0);
  assign do_deq = deq && !empty && !flush;

  always_comb begin
    if (head_q[IDX_W] == tail_q[IDX_W]) begin
      count = PTR_W'(tail_idx) - PTR_W'(head_idx);
    end else begin
      count = PTR_W'(DEPTH) - PTR_W'(head_idx) + PTR_W'(tail_idx);
    end
  end

  always_comb begin
    tail_d = do_enq ? ptr_inc(tail_q) : tail_q;
    head_d = head_q;
    // Flush makes every slot free again, including those just handed out speculatively.
    if (flush) begin
      head_d = {~tail_d[IDX_W], tail_d[IDX_W-1:0]};
    end else if (do_deq) begin
      head_d = ptr_inc(head_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= {1'b1, {IDX_W{1'b0}}};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= PHYS_REG_BITS'(ARCH_REGS + i);
      end
    end else if (do_enq) begin
      mem_q[tail_idx] <= pd_in;
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: stimulus queues expected observations, a negedge monitor checks them.
module tb_free_list;

  logic       clk = 1'b0;
  logic       rst, deq, enq, flush;
  logic [5:0] pd_in, pd_out, count;
  logic       empty, full;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [5:0] pd;
    bit         chk_pd;
    logic       emp;
    logic       ful;
    logic [5:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  free_list dut (
    .clk    (clk),
    .rst    (rst),
    .deq    (deq),
    .pd_out (pd_out),
    .empty  (empty),
    .enq    (enq),
    .pd_in  (pd_in),
    .full   (full),
    .flush  (flush),
    .count  (count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && enq && full) begin
      errors++;
      $display("FAIL enq_while_full at cycle %0d: enq asserted while full=%0d, required no enq", cyc, full);
    end
    while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_pd) begin
        checks++;
        if (pd_out !== e.pd) begin
          errors++;
          $display("FAIL %s pd_out: got %0d expected %0d", e.name, pd_out, e.pd);
        end
      end
      checks++;
      if (empty !== e.emp) begin
        errors++;
        $display("FAIL %s empty: got %0d expected %0d", e.name, empty, e.emp);
      end
      checks++;
      if (full !== e.ful) begin
        errors++;
        $display("FAIL %s full: got %0d expected %0d", e.name, full, e.ful);
      end
      checks++;
      if (count !== e.cnt) begin
        errors++;
        $display("FAIL %s count: got %0d expected %0d", e.name, count, e.cnt);
      end
    end
  end

  task automatic expect_now(input string name, input bit chk_pd, input logic [5:0] pd,
                            input logic emp, input logic ful, input logic [5:0] cnt);
    exp_t e;
    e.cyc = cyc; e.name = name; e.pd = pd; e.chk_pd = chk_pd;
    e.emp = emp; e.ful = ful; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic cycle(input logic d, input logic e, input logic [5:0] p,
                       input logic f, input logic r);
    deq = d; enq = e; pd_in = p; flush = f; rst = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    deq = 0; enq = 0; pd_in = 0; flush = 0; rst = 1;
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    rst = 0;

    expect_now("reset", 1, 6'd32, 0, 1, 6'd32);
    for (int i = 0; i < 32; i++) begin
      expect_now("drain", 1, 6'(32 + i), 0, (i == 0), 6'(32 - i));
      cycle(1, 0, 0, 0, 0);
    end
    expect_now("drained", 0, 0, 1, 0, 0);
    cycle(1, 0, 0, 0, 0);
    expect_now("deq_empty", 0, 0, 1, 0, 0);

    // From empty: enqueued value is not visible until the following cycle.
    cycle(0, 1, 6'd40, 0, 0);
    expect_now("enq_next", 1, 6'd40, 0, 0, 6'd1);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 6'(40 + i), 0, 0);
    expect_now("count5", 1, 6'd40, 0, 0, 6'd5);
    cycle(1, 1, 6'd50, 0, 0);
    expect_now("simul", 1, 6'd41, 0, 0, 6'd5);
    for (int i = 0; i < 5; i++) begin
      expect_now("simul_order", 1, (i < 4) ? 6'(41 + i) : 6'd50, 0, 0, 6'(5 - i));
      cycle(1, 0, 0, 0, 0);
    end
    expect_now("simul_empty", 0, 0, 1, 0, 0);

    // Pointers sit at slot 6, so each refill and drain crosses the wrap point.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 32; i++) cycle(0, 1, 6'(63 - i), 0, 0);
      expect_now("wrap_full", 1, 6'd63, 0, 1, 6'd32);
      for (int i = 0; i < 32; i++) begin
        expect_now("wrap_order", 1, 6'(63 - i), 0, (i == 0), 6'(32 - i));
        cycle(1, 0, 0, 0, 0);
      end
      expect_now("wrap_empty", 0, 0, 1, 0, 0);
    end

    for (int i = 0; i < 32; i++) cycle(0, 1, 6'(63 - i), 0, 0);
    for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 0);
    expect_now("pre_flush", 1, 6'd53, 0, 0, 6'd22);
    cycle(1, 1, 6'd33, 1, 0);
    expect_now("flush", 1, 6'd62, 0, 1, 6'd32);
    cycle(1, 0, 0, 0, 0);
    expect_now("post_flush_deq", 1, 6'd61, 0, 0, 6'd31);
    cycle(0, 1, 6'd0, 0, 0);
    expect_now("enq_zero", 1, 6'd61, 0, 0, 6'd31);

    cycle(1, 1, 6'd45, 0, 0);
    cycle(1, 1, 6'd46, 0, 0);
    cycle(1, 1, 6'd47, 1, 1);
    expect_now("mid_reset", 1, 6'd32, 0, 1, 6'd32);
    cycle(1, 0, 0, 0, 0);
    expect_now("reset_mem1", 1, 6'd33, 0, 0, 6'd31);
    cycle(1, 0, 0, 0, 0);
    expect_now("reset_mem2", 1, 6'd34, 0, 0, 6'd30);
    cycle(0, 0, 0, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) cycle(0, 0, 0, 0, 0);
    if (exp_q.size() > 0) begin
      errors += exp_q.size();
      $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/free_list.md
# free_list

Circular FIFO of free physical register indices for the out-of-order core. It feeds the dispatch/rename stage: the index at its head is the `pd_dispatch` that the rename table maps to a newly renamed `rd`. Physical registers return to the tail when commit retires an instruction and releases the register's previous mapping. On a pipeline flush the list is restored to full in one cycle.

## Interface
Parameters:
- PHYS_REG_BITS, 6, width of a physical register index.
- NUM_PHYS, 1 << PHYS_REG_BITS, total physical registers.
- DEPTH, NUM_PHYS - 32, number of list slots (32 with defaults).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- deq  in  1  dispatch consumes the head entry this cycle
- pd_out  out  PHYS_REG_BITS  free register at head, valid when !empty
- empty  out  1  no free register available
- enq  in  1  commit returns a register
- pd_in  in  PHYS_REG_BITS  register being returned
- full  out  1  all DEPTH slots hold free registers
- flush  in  1  mispredict/exception recovery
- count  out  $clog2(DEPTH)+1  number of free entries

## Operation
- Storage: DEPTH entries of PHYS_REG_BITS each. head and tail pointers are $clog2(DEPTH) index bits plus one wrap bit.
- empty = (head == tail). full = index bits equal and wrap bits differ. count = tail - head over all bits.
- pd_out = mem[head index], combinational read.
- Dequeue: deq && !empty advances head by 1. The slot is not cleared. deq while empty is ignored, with no state change, and dispatch must stall.
- Enqueue: enq && !full && pd_in != 0 writes mem[tail] = pd_in and advances tail by 1.
  - pd_in == 0 is ignored, because physical register 0 is permanently x0.
  - enq while full is ignored. This is an illegal condition and the bench asserts on it.
- No enq-to-deq bypass. A register enqueued into an empty list is dequeuable the next cycle.
- Simultaneous enq and deq on a non-empty, non-full list: both take effect, and count is unchanged.
- Flush: head_next = tail_next with its wrap bit inverted, so the list becomes full.
  - Slots behind head still hold the speculatively allocated registers, so every register not held by the committed map becomes free again.
  - An enq in the flush cycle is performed first; the new tail is used.
  - A deq in the flush cycle is discarded.
- Reset: mem[i] = 32 + i for i in 0..DEPTH-1. head = 0 with wrap 0. tail = 0 with wrap 1. Reset overrides flush, enq and deq.
- Outputs after reset: pd_out = 32, empty = 0, full = 1, count = DEPTH.

## Timing
- pd_out and empty reflect registered state in the same cycle, so dispatch samples them combinationally.
- deq, enq and flush take effect at the next rising clk.
- Write-to-readout latency is 1 cycle; there is no same-cycle forwarding.
- Wrap-around: pointer index DEPTH-1 + 1 goes to 0 and toggles the wrap bit.
- Single-cycle flush recovery: the cycle after flush, full = 1 and count = DEPTH.

## Structure
- The shared package (rv32i_types) holds the ARCH_REGS = 32 constant and the physical-register index typedef sized by PHYS_REG_BITS. The rename table uses the same definitions.
- No sub-module. Storage, pointers and flag logic stay inline in this module.
- Expected RTL size is about 120–160 lines.

## Test plan
- Reset, then 32 consecutive deq:
  - pd_out sequence is 32, 33, …, 63.
  - After the last deq, empty = 1 and count = 0.
  - A further deq leaves head unchanged.
- From empty, enq pd_in = 40:
  - Same cycle: empty stays 1.
  - Next cycle: pd_out = 40, count = 1.
- Simultaneous enq (pd_in = 50) and deq with count = 5: count stays 5, the head advances, and 50 appears after the existing 4 entries.
- Wrap: 32 deq, then 32 enq of 63 down to 32, repeated twice. The order is preserved across pointer wrap, and full = 1 after each refill.
- Flush after 10 deq with an enq of 33 in the same cycle:
  - Next cycle: full = 1, count = 32, and pd_out = the first slot after tail.
  - enq pd_in = 0 is ignored and count stays unchanged.
- Assert rst during a deq/enq stream: the next cycle matches the reset state exactly (pd_out = 32, full = 1, count = 32).
